pwm_compare_stage: RTL and testbench

- Downstream consumer of the modulo-N counter; takes the counter's count output and generates a registered PWM waveform by comparing it against a duty value.
- Duty and polarity are written through a valid/ready config port into a shadow register. They take effect only at a period boundary (count returning to 0), so the output never glitches mid-period.
- Also emits a one-cycle period-start pulse and a wrapping count of started periods for downstream timers.

---
 rtl/pwm_compare_stage_if.sv | 12 +
 rtl/pwm_compare_stage.sv | 104 ++++++++++
 tb/tb_pwm_compare_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_compare_stage_if.sv
// Config port of the PWM compare stage: duty/polarity word offered with a valid/ready handshake.
interface pwm_compare_stage_if #(
    parameter int unsigned N = 4
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [N:0]   cfg_duty;
    logic         cfg_invert;

    modport master (output cfg_valid, output cfg_duty, output cfg_invert, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_duty, input cfg_invert, output cfg_ready);
endinterface

// File: rtl/pwm_compare_stage.sv
// Registered PWM generator fed by an upstream modulo-COUNT counter; duty/polarity
// updates are shadowed and only take effect at a period start.
module pwm_compare_stage #(
    parameter int unsigned N     = 4,
    parameter int unsigned COUNT = 16
) (
    input  logic                clock,
    input  logic                clear_n,
    input  logic [N-1:0]        cnt_in,
    pwm_compare_stage_if.slave  cfg,
    output logic                pwm_out,
    output logic                wrap_pulse,
    output logic [7:0]          periods
);

    localparam logic [N:0] COUNT_W = COUNT[N:0];

    logic [N-1:0] prev_cnt_q,    prev_cnt_d;
    logic         first_q,       first_d;
    logic         pending_q,     pending_d;
    logic [N:0]   pend_duty_q,   pend_duty_d;
    logic         pend_inv_q,    pend_inv_d;
    logic [N:0]   active_duty_q, active_duty_d;
    logic         active_inv_q,  active_inv_d;
    logic         cfg_ready_q,   cfg_ready_d;
    logic         pwm_q,         pwm_d;
    logic         wrap_q,        wrap_d;
    logic [7:0]   periods_q,     periods_d;

    logic         start;
    logic         accept;
    logic [N:0]   eff_duty;
    logic         eff_inv;
    logic [N:0]   duty_clamped;

    // A start is the first cycle of a run of zeros, so a held zero counts once.
    assign start        = (cnt_in == '0) && (first_q || (prev_cnt_q != '0));
    assign accept       = cfg.cfg_valid && cfg_ready_q;
    assign eff_duty     = (start && pending_q) ? pend_duty_q : active_duty_q;
    assign eff_inv      = (start && pending_q) ? pend_inv_q  : active_inv_q;
    assign duty_clamped = (cfg.cfg_duty > COUNT_W) ? COUNT_W : cfg.cfg_duty;

    always_comb begin
        prev_cnt_d    = cnt_in;
        first_d       = 1'b0;
        pending_d     = pending_q;
        pend_duty_d   = pend_duty_q;
        pend_inv_d    = pend_inv_q;
        active_duty_d = active_duty_q;
        active_inv_d  = active_inv_q;
        cfg_ready_d   = cfg_ready_q;
        pwm_d         = ({1'b0, cnt_in} < eff_duty) ^ eff_inv;
        wrap_d        = start;
        periods_d     = periods_q + {7'd0, start};

        if (start && pending_q) begin
            active_duty_d = pend_duty_q;
            active_inv_d  = pend_inv_q;
            pending_d     = 1'b0;
            cfg_ready_d   = 1'b1;
        end
        // Accept only happens with nothing pending, so it never races the consume above.
        if (accept) begin
            pend_duty_d = duty_clamped;
            pend_inv_d  = cfg.cfg_invert;
            pending_d   = 1'b1;
            cfg_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            prev_cnt_q    <= '0;
            first_q       <= 1'b1;
            pending_q     <= 1'b0;
            pend_duty_q   <= '0;
            pend_inv_q    <= 1'b0;
            active_duty_q <= '0;
            active_inv_q  <= 1'b0;
            cfg_ready_q   <= 1'b1;
            pwm_q         <= 1'b0;
            wrap_q        <= 1'b0;
            periods_q     <= '0;
        end else begin
            prev_cnt_q    <= prev_cnt_d;
            first_q       <= first_d;
            pending_q     <= pending_d;
            pend_duty_q   <= pend_duty_d;
            pend_inv_q    <= pend_inv_d;
            active_duty_q <= active_duty_d;
            active_inv_q  <= active_inv_d;
            cfg_ready_q   <= cfg_ready_d;
            pwm_q         <= pwm_d;
            wrap_q        <= wrap_d;
            periods_q     <= periods_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign pwm_out       = pwm_q;
    assign wrap_pulse    = wrap_q;
    assign periods       = periods_q;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Directed bench for pwm_compare_stage (N=4, COUNT=16) with hand-derived expectations.
module tb_pwm_compare_stage;

    logic       clock = 1'b0;
    logic       clear_n;
    logic [3:0] cnt_in;
    logic       pwm_out;
    logic       wrap_pulse;
    logic [7:0] periods;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_periods;

    pwm_compare_stage_if #(.N(4)) cfg_if ();

    pwm_compare_stage #(.N(4), .COUNT(16)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .cnt_in     (cnt_in),
        .cfg        (cfg_if.slave),
        .pwm_out    (pwm_out),
        .wrap_pulse (wrap_pulse),
        .periods    (periods)
    );

    always #5 clock = ~clock;

    // Drive cnt_in, let one rising edge register it, then settle 1 ns past the edge.
    task automatic tick(input logic [3:0] c);
        cnt_in = c;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        clear_n = 1'b0;
        cnt_in = 4'd0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_duty = 5'd0;
        cfg_if.cfg_invert = 1'b0;
        exp_periods = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        tests_run++; if (wrap_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap got %b want 0", wrap_pulse); end
        tests_run++; if (cfg_if.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", cfg_if.cfg_ready); end
        tests_run++; if (periods !== 8'd0) begin tests_failed++; $display("FAIL reset_periods got %0d want 0", periods); end
        clear_n = 1'b1;
    endtask

    task automatic test_sweep;
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 16; c++) begin
                tick(4'(c));
                if (c == 0) exp_periods++;
                tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL sweep_pwm c=%0d got %b want 0", c, pwm_out); end
                tests_run++; if (wrap_pulse !== (c == 0)) begin tests_failed++; $display("FAIL sweep_wrap c=%0d got %b want %b", c, wrap_pulse, (c == 0)); end
                tests_run++; if (periods !== exp_periods) begin tests_failed++; $display("FAIL sweep_periods c=%0d got %0d want %0d", c, periods, exp_periods); end
            end
        end
    endtask

    task automatic test_config;
        for (int c = 0; c < 16; c++) begin
            if (c == 7) begin
                cfg_if.cfg_valid = 1'b1; cfg_if.cfg_duty = 5'd4; cfg_if.cfg_invert = 1'b0;
            end
            tick(4'(c));
            cfg_if.cfg_valid = 1'b0;
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL cfg_old_pwm c=%0d got %b want 0", c, pwm_out); end
            if (c >= 7) begin
                tests_run++; if (cfg_if.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL cfg_ready_low c=%0d got %b want 0", c, cfg_if.cfg_ready); end
            end
        end
        for (int c = 0; c < 16; c++) begin
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== (c < 4)) begin tests_failed++; $display("FAIL cfg_new_pwm c=%0d got %b want %b", c, pwm_out, (c < 4)); end
            tests_run++; if (periods !== exp_periods) begin tests_failed++; $display("FAIL cfg_periods c=%0d got %0d want %0d", c, periods, exp_periods); end
            if (c == 0) begin
                tests_run++; if (cfg_if.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL cfg_ready_back got %b want 1", cfg_if.cfg_ready); end
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 16; c++) begin
            if (c == 0) begin
                cfg_if.cfg_valid = 1'b1; cfg_if.cfg_duty = 5'd10; cfg_if.cfg_invert = 1'b0;
            end
            tick(4'(c));
            cfg_if.cfg_valid = 1'b0;
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== (c < 4)) begin tests_failed++; $display("FAIL same_cycle_old_pwm c=%0d got %b want %b", c, pwm_out, (c < 4)); end
            tests_run++; if (cfg_if.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL same_cycle_ready c=%0d got %b want 0", c, cfg_if.cfg_ready); end
        end
        for (int c = 0; c < 16; c++) begin
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== (c < 10)) begin tests_failed++; $display("FAIL same_cycle_new_pwm c=%0d got %b want %b", c, pwm_out, (c < 10)); end
            tests_run++; if (cfg_if.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL same_cycle_ready_back c=%0d got %b want 1", c, cfg_if.cfg_ready); end
        end
    endtask

    task automatic test_clamp;
        for (int c = 0; c < 16; c++) begin
            if (c == 3) begin
                cfg_if.cfg_valid = 1'b1; cfg_if.cfg_duty = 5'd31; cfg_if.cfg_invert = 1'b1;
            end else if (c >= 4 && c < 15) begin
                cfg_if.cfg_valid = 1'b1; cfg_if.cfg_duty = 5'd2; cfg_if.cfg_invert = 1'b0;
            end else begin
                cfg_if.cfg_valid = 1'b0;
            end
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== (c < 10)) begin tests_failed++; $display("FAIL clamp_old_pwm c=%0d got %b want %b", c, pwm_out, (c < 10)); end
            if (c >= 3) begin
                tests_run++; if (cfg_if.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL clamp_ready_low c=%0d got %b want 0", c, cfg_if.cfg_ready); end
            end
        end
        cfg_if.cfg_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL clamp_pwm c=%0d got %b want 0", c, pwm_out); end
            tests_run++; if (periods !== exp_periods) begin tests_failed++; $display("FAIL clamp_periods c=%0d got %0d want %0d", c, periods, exp_periods); end
        end
    endtask

    task automatic test_duty_zero;
        for (int c = 0; c < 16; c++) begin
            cfg_if.cfg_valid = (c == 1);
            cfg_if.cfg_duty = 5'd0;
            cfg_if.cfg_invert = 1'b1;
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL zero_old_pwm c=%0d got %b want 0", c, pwm_out); end
        end
        cfg_if.cfg_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== 1'b1) begin tests_failed++; $display("FAIL zero_inv_pwm c=%0d got %b want 1", c, pwm_out); end
        end
    endtask

    task automatic test_upstream_clear;
        for (int c = 0; c < 10; c++) begin
            cfg_if.cfg_valid = (c == 2);
            cfg_if.cfg_duty = 5'd6;
            cfg_if.cfg_invert = 1'b1;
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (pwm_out !== 1'b1) begin tests_failed++; $display("FAIL clr_old_pwm c=%0d got %b want 1", c, pwm_out); end
        end
        cfg_if.cfg_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(4'd0);
            if (k == 0) exp_periods++;
            tests_run++; if (wrap_pulse !== (k == 0)) begin tests_failed++; $display("FAIL clr_wrap k=%0d got %b want %b", k, wrap_pulse, (k == 0)); end
            tests_run++; if (periods !== exp_periods) begin tests_failed++; $display("FAIL clr_periods k=%0d got %0d want %0d", k, periods, exp_periods); end
            tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL clr_new_pwm k=%0d got %b want 0", k, pwm_out); end
            tests_run++; if (cfg_if.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL clr_ready k=%0d got %b want 1", k, cfg_if.cfg_ready); end
        end
        for (int c = 1; c < 10; c++) begin
            tick(4'(c));
            tests_run++; if (pwm_out !== !(c < 6)) begin tests_failed++; $display("FAIL clr_run_pwm c=%0d got %b want %b", c, pwm_out, !(c < 6)); end
        end
    endtask

    task automatic test_async_reset;
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_duty = 5'd12; cfg_if.cfg_invert = 1'b0;
        tick(4'd10);
        cfg_if.cfg_valid = 1'b0;
        tick(4'd11);
        tests_run++; if (cfg_if.cfg_ready !== 1'b0) begin tests_failed++; $display("FAIL arst_pending_ready got %b want 0", cfg_if.cfg_ready); end
        tests_run++; if (pwm_out !== 1'b1) begin tests_failed++; $display("FAIL arst_pre_pwm got %b want 1", pwm_out); end
        #2 clear_n = 1'b0;
        #1;
        exp_periods = 8'd0;
        tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL arst_pwm got %b want 0", pwm_out); end
        tests_run++; if (wrap_pulse !== 1'b0) begin tests_failed++; $display("FAIL arst_wrap got %b want 0", wrap_pulse); end
        tests_run++; if (cfg_if.cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL arst_ready got %b want 1", cfg_if.cfg_ready); end
        tests_run++; if (periods !== 8'd0) begin tests_failed++; $display("FAIL arst_periods got %0d want 0", periods); end
        cnt_in = 4'd0;
        #2 clear_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick(4'(c));
            if (c == 0) exp_periods++;
            tests_run++; if (wrap_pulse !== (c == 0)) begin tests_failed++; $display("FAIL arst_post_wrap c=%0d got %b want %b", c, wrap_pulse, (c == 0)); end
            tests_run++; if (periods !== exp_periods) begin tests_failed++; $display("FAIL arst_post_periods c=%0d got %0d want %0d", c, periods, exp_periods); end
            tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL arst_post_pwm c=%0d got %b want 0", c, pwm_out); end
        end
        tick(4'd0);
        tests_run++; if (periods !== 8'd2) begin tests_failed++; $display("FAIL arst_second_period got %0d want 2", periods); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_config();
        test_back_to_back();
        test_clamp();
        test_duty_zero();
        test_upstream_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
